// File: rtl/display_pkg.sv
// Segment encodings shared by the BCD scan driver and its decoder.
// Bit order is {g,f,e,d,c,b,a}, active-high.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bundle between the BCD source and the scanned display driver.
// Master feeds BCD words; slave drives the digit array.
interface bcd_display_scan_if
  import display_pkg::*;
#(
  parameter int DIGITS = 3
);

  logic [4*DIGITS-1:0] bcd;
  logic                load;
  logic                blank_lz;
  logic [DIGITS-1:0]   an;
  seg_t                seg;
  logic                frame_done;

  modport master (
    output bcd, load, blank_lz,
    input  an, seg, frame_done
  );

  modport slave (
    input  bcd, load, blank_lz,
    output an, seg, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Nibble to seven-segment pattern; non-decimal nibbles show a dash.
// Purely combinational.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment scanner with frame-aligned commit
// of BCD words, leading-zero blanking and dash for bad nibbles.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 4
)(
  input logic               clk,
  input logic               rst,
  bcd_display_scan_if.slave bus
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  localparam logic [TW-1:0]     TMAX = TW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IMAX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE  = DIGITS'(1);

  logic [TW-1:0] tick, tick_n;
  logic [IW-1:0] idx, idx_n;
  logic [BW-1:0] pend, pend_n;
  logic [BW-1:0] shadow, shadow_n;
  logic [BW-1:0] upper;
  logic          run;
  logic          wrap;
  logic          bound;
  logic [3:0]    nib;
  seg_t          dec;
  seg_t          seg_n;

  // run holds the counters on the first edge after reset so the
  // first digit gets a full dwell once outputs become valid.
  always_comb begin
    wrap     = run && (tick == TMAX);
    bound    = wrap && (idx == IMAX);
    tick_n   = tick;
    idx_n    = idx;
    if (run)
      tick_n = wrap ? '0 : tick + 1'b1;
    if (wrap)
      idx_n = (idx == IMAX) ? '0 : idx + 1'b1;
    pend_n   = bus.load ? bus.bcd : pend;
    shadow_n = bound ? pend_n : shadow;
    upper    = shadow_n >> {idx_n, 2'b00};
    nib      = upper[3:0];
    seg_n    = dec;
    if (bus.blank_lz && (idx_n != '0) && (upper == '0))
      seg_n  = SEG_BLANK;
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      run            <= 1'b0;
      tick           <= '0;
      idx            <= '0;
      pend           <= '0;
      shadow         <= '0;
      bus.an         <= '0;
      bus.seg        <= SEG_BLANK;
      bus.frame_done <= 1'b0;
    end else begin
      run            <= 1'b1;
      tick           <= tick_n;
      idx            <= idx_n;
      pend           <= pend_n;
      shadow         <= shadow_n;
      bus.an         <= ONE << idx_n;
      bus.seg        <= seg_n;
      bus.frame_done <= bound;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: directed scenarios plus random loads,
// all checked every cycle against a frame-level display model.
module tb_bcd_display_scan;
  import display_pkg::*;

  localparam int D     = 3;
  localparam int P     = 4;
  localparam int FRAME = D * P;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_display_scan_if #(.DIGITS(D)) bus ();

  bcd_display_scan #(
    .DIGITS   (D),
    .PRESCALE (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: display position counted from reset release.
  logic [6:0] tbl [10];
  initial begin
    tbl[0] = 7'b0111111; tbl[1] = 7'b0000110;
    tbl[2] = 7'b1011011; tbl[3] = 7'b1001111;
    tbl[4] = 7'b1100110; tbl[5] = 7'b1101101;
    tbl[6] = 7'b1111101; tbl[7] = 7'b0000111;
    tbl[8] = 7'b1111111; tbl[9] = 7'b1101111;
  end

  function automatic logic [6:0] model_seg(input logic [11:0] w,
                                           input int d,
                                           input logic blank);
    logic [11:0] up;
    int v;
    up = w >> (4 * d);
    v  = int'(up[3:0]);
    if (blank && d > 0 && up == 12'h0)
      return 7'b0000000;
    if (v > 9)
      return 7'b1000000;
    return tbl[v];
  endfunction

  logic        mvalid = 1'b0;
  logic [11:0] m_pend, m_shown;
  int          m_c;
  logic [2:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  always @(posedge clk) begin
    if (rst) begin
      mvalid  = 1'b1;
      m_pend  = 12'h0;
      m_shown = 12'h0;
      m_c     = -1;
      e_an    = 3'b000;
      e_seg   = 7'b0;
      e_fd    = 1'b0;
    end else if (mvalid) begin
      int d;
      if (bus.load)
        m_pend = bus.bcd;
      m_c++;
      e_fd = (m_c > 0) && (m_c % FRAME == 0);
      if (e_fd)
        m_shown = m_pend;
      d     = (m_c / P) % D;
      e_an  = 3'b001 << d;
      e_seg = model_seg(m_shown, d, bus.blank_lz);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_an", bus.an, e_an);
      chk("model_seg", bus.seg, e_seg);
      chk("model_frame_done", bus.frame_done, e_fd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [11:0] w);
    bus.bcd  = w;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic frame_start();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!e_fd && k < 100);
    if (k >= 100)
      chk("frame_timeout", 1, 0);
  endtask

  task automatic chk_frame(input logic [6:0] s0, s1, s2);
    frame_start();
    chk("lit_fd", bus.frame_done, 1);
    chk("lit_an0", bus.an, 3'b001);
    chk("lit_seg0", bus.seg, s0);
    step(P);
    chk("lit_an1", bus.an, 3'b010);
    chk("lit_seg1", bus.seg, s1);
    step(P);
    chk("lit_an2", bus.an, 3'b100);
    chk("lit_seg2", bus.seg, s2);
  endtask

  initial begin
    rst          = 1'b1;
    bus.bcd      = 12'h123;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset and first frame timing
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", bus.an, 0);
      chk("rst_seg", bus.seg, 0);
      chk("rst_fd", bus.frame_done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("first_an", bus.an, 3'b001 << (i / P));
      chk("first_seg", bus.seg, 7'b0111111);
      chk("first_fd", bus.frame_done, 0);
    end
    @(negedge clk);
    chk("first_wrap_fd", bus.frame_done, 1);
    chk("first_wrap_an", bus.an, 3'b001);

    // Mid-frame load at idx 1
    step(P);
    chk("mid_an", bus.an, 3'b010);
    do_load(12'h259);
    step(P - 1);
    chk("mid_old_an", bus.an, 3'b100);
    chk("mid_old_seg", bus.seg, 7'b0111111);
    chk_frame(7'b1101111, 7'b1101101, 7'b1011011);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(12'h007);
    chk_frame(7'b0000111, 7'b0000000, 7'b0000000);
    do_load(12'h000);
    chk_frame(7'b0111111, 7'b0000000, 7'b0000000);
    do_load(12'h050);
    chk_frame(7'b0111111, 7'b1101101, 7'b0000000);
    bus.blank_lz = 1'b0;

    // Invalid nibbles
    do_load(12'hA0F);
    chk_frame(7'b1000000, 7'b0111111, 7'b1000000);

    // Load in the boundary cycle is bypassed into the new frame
    step(P - 1);
    do_load(12'h111);
    chk("byp_fd", bus.frame_done, 1);
    chk("byp_an0", bus.an, 3'b001);
    chk("byp_seg0", bus.seg, 7'b0000110);
    step(P);
    chk("byp_seg1", bus.seg, 7'b0000110);
    step(P);
    chk("byp_seg2", bus.seg, 7'b0000110);

    // Last load of a frame wins
    do_load(12'h222);
    step(1);
    do_load(12'h333);
    chk_frame(7'b1001111, 7'b1001111, 7'b1001111);

    // Reset mid-scan discards pending and overrides load
    do_load(12'h999);
    chk_frame(7'b1101111, 7'b1101111, 7'b1101111);
    rst      = 1'b1;
    bus.bcd  = 12'h555;
    bus.load = 1'b1;
    @(negedge clk);
    chk("mrst_an", bus.an, 0);
    chk("mrst_seg", bus.seg, 0);
    rst      = 1'b0;
    bus.load = 1'b0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      chk("mrst_dwell_an", bus.an, 3'b001);
      chk("mrst_dwell_seg", bus.seg, 7'b0111111);
    end
    @(negedge clk);
    chk("mrst_next_an", bus.an, 3'b010);
    chk_frame(7'b0111111, 7'b0111111, 7'b0111111);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] w;
      for (int k = 0; k < 3; k++)
        w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0
                      : 4'($urandom_range(0, 15));
      bus.bcd  = w;
      bus.load = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0)
        bus.blank_lz = ~bus.blank_lz;
      @(negedge clk);
    end
    rst      = 1'b0;
    bus.load = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
